// File: rtl/arkanoid_game_ctrl.sv
// Game-flow controller for the arkanoid playfield: owns the BCD score and ball count,
// sequences NEWGAME/PLAY/NEWBALL/OVER and drives text enables and freeze/respawn controls.
module arkanoid_game_ctrl #(
  parameter int BALLS_INIT    = 3,
  parameter int NEWBALL_TICKS = 30,
  parameter int OVER_TICKS    = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn,
  input  logic       brick_hit,
  input  logic       ball_miss,
  input  logic       bricks_clear,
  output logic [3:0] one_digit,
  output logic [3:0] ten_digit,
  output logic [1:0] ball,
  output logic [3:0] text_en,
  output logic       graphics_still,
  output logic       ball_reset
);

  localparam int TMAX    = (NEWBALL_TICKS > OVER_TICKS) ? NEWBALL_TICKS : OVER_TICKS;
  localparam int TIMER_W = $clog2(TMAX + 1);

  localparam logic [TIMER_W-1:0] T_NEWBALL = TIMER_W'(NEWBALL_TICKS);
  localparam logic [TIMER_W-1:0] T_OVER    = TIMER_W'(OVER_TICKS);
  localparam logic [TIMER_W-1:0] T_SAT     = '1;
  localparam logic [1:0]         BALLS_RST = 2'(BALLS_INIT);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [3:0]           one_nxt, ten_nxt;
  logic [1:0]           ball_nxt;
  logic                 ball_reset_nxt;
  logic                 play_from_newgame;
  logic                 btn_q;
  logic                 btn_armed;
  logic                 launch_q;
  logic                 launch_d;

  // Score increment in BCD, saturating at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [3:0] ten, input logic [3:0] one);
    if (ten == 4'd9 && one == 4'd9) return {ten, one};
    if (one == 4'd9)                return {ten + 4'd1, 4'd0};
    return {ten, one + 4'd1};
  endfunction

  // Region enables {score, pong, rule, over} per state.
  function automatic logic [3:0] text_en_of(input state_t s);
    case (s)
      NEWGAME: return 4'b1110;
      OVER:    return 4'b1001;
      default: return 4'b1000;
    endcase
  endfunction

  // A button already held when reset releases must first be seen low before it can launch.
  assign launch_d = btn & ~btn_q & btn_armed;

  always_comb begin
    state_nxt         = state;
    one_nxt           = one_digit;
    ten_nxt           = ten_digit;
    ball_nxt          = ball;
    timer_nxt         = timer;
    play_from_newgame = 1'b0;

    if (tick && timer != T_SAT) timer_nxt = timer + 1'b1;

    case (state)
      NEWGAME: begin
        timer_nxt = '0;
        one_nxt   = 4'd0;
        ten_nxt   = 4'd0;
        ball_nxt  = BALLS_RST;
        if (launch_q) begin
          state_nxt         = PLAY;
          play_from_newgame = 1'b1;
        end
      end
      PLAY: begin
        timer_nxt = '0;
        if (brick_hit) {ten_nxt, one_nxt} = bcd_inc_sat(ten_digit, one_digit);
        if (ball_miss) begin
          ball_nxt  = ball - 2'd1;
          state_nxt = (ball == 2'd1) ? OVER : NEWBALL;
        end else if (bricks_clear) begin
          state_nxt = OVER;
        end
      end
      NEWBALL: begin
        if (launch_q && timer >= T_NEWBALL) state_nxt = PLAY;
      end
      OVER: begin
        if (timer == T_OVER) begin
          state_nxt = NEWGAME;
          one_nxt   = 4'd0;
          ten_nxt   = 4'd0;
          ball_nxt  = BALLS_RST;
        end
      end
      default: state_nxt = NEWGAME;
    endcase

    if (state_nxt != state) timer_nxt = '0;

    // A miss on the very first PLAY cycle would otherwise stretch the pulse to two cycles.
    ball_reset_nxt = (play_from_newgame || (state_nxt == NEWBALL && state != NEWBALL))
                     && !ball_reset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= NEWGAME;
      timer          <= '0;
      btn_q          <= 1'b0;
      btn_armed      <= 1'b0;
      launch_q       <= 1'b0;
      one_digit      <= 4'd0;
      ten_digit      <= 4'd0;
      ball           <= BALLS_RST;
      text_en        <= 4'b1110;
      graphics_still <= 1'b1;
      ball_reset     <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      btn_q          <= btn;
      btn_armed      <= btn_armed | ~btn;
      launch_q       <= launch_d;
      one_digit      <= one_nxt;
      ten_digit      <= ten_nxt;
      ball           <= ball_nxt;
      text_en        <= text_en_of(state_nxt);
      graphics_still <= (state_nxt != PLAY);
      ball_reset     <= ball_reset_nxt;
    end
  end

endmodule
